// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_pkg
//  Purpose  : Shared constants and width helper for the debounce bank.
//  Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

  // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
  function automatic int clog2(input int unsigned value);
    int          r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int c_default_limit      = 250000;
  localparam int c_default_tick_div   = 1;
  localparam int c_default_hold_limit = 1000000;
  localparam int c_cnt_w              = clog2(c_default_limit + 1);

endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_chan
//  Purpose  : One debounce channel: 2-flop sync, stability counter, level,
//             rise/fall pulses; long-press hold pulse with DEBOUNCE_HOLD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   LIMIT       = c_default_limit,
  parameter int   HOLD_LIMIT  = c_default_hold_limit,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam int                    c_cnt_width = clog2(LIMIT + 1);
  localparam logic [c_cnt_width-1:0] c_cnt_last = c_cnt_width'(LIMIT - 1);

  logic                   r_sync1;
  logic                   r_sync2;
  logic [c_cnt_width-1:0] r_count;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
    end
  end

  // Any edge where the synced input agrees with level restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_level <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync2 == r_level) begin
        r_count <= '0;
      end else if (tick) begin
        if (r_count == c_cnt_last) begin
          r_level <= r_sync2;
          r_count <= '0;
          r_rise  <= r_sync2;
          r_fall  <= ~r_sync2;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

`ifdef DEBOUNCE_HOLD_EN
  localparam int                     c_hold_width = clog2(HOLD_LIMIT + 1);
  localparam logic [c_hold_width-1:0] c_hold_max  = c_hold_width'(HOLD_LIMIT);

  logic [c_hold_width-1:0] r_hold_cnt;
  logic                    r_hold;

  // Saturating counter so hold fires exactly once per press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold_cnt <= '0;
      r_hold     <= 1'b0;
    end else begin
      r_hold <= 1'b0;
      if (!r_level) begin
        r_hold_cnt <= '0;
      end else if (tick && (r_hold_cnt != c_hold_max)) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
        r_hold     <= (r_hold_cnt == c_hold_max - 1'b1);
      end
    end
  end

  assign hold = r_hold;
`else
  // HOLD_LIMIT only sizes the long-press counter, which is absent here.
  if (HOLD_LIMIT >= 1) begin : g_hold_off
    assign hold = 1'b0;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_bank
//  Purpose  : NUM_CH independent debouncers sharing one tick prescaler.
//             Define DEBOUNCE_HOLD_EN to build the per-channel long-press
//             hold pulse; otherwise hold is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   NUM_CH      = 4,
  parameter int   LIMIT       = c_default_limit,
  parameter int   TICK_DIV    = c_default_tick_div,
  parameter logic RESET_LEVEL = 1'b0,
  parameter int   HOLD_LIMIT  = c_default_hold_limit
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] in,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] hold
);

  localparam int                  c_div_w    = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
  localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(TICK_DIV - 1);

  logic [c_div_w-1:0] r_div;
  logic               r_tick;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (r_div == c_div_last) begin
      r_div  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_div  <= r_div + 1'b1;
      r_tick <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    debounce_chan #(
      .LIMIT       (LIMIT),
      .HOLD_LIMIT  (HOLD_LIMIT),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_chan (
      .clock (clock),
      .reset (reset),
      .tick  (r_tick),
      .in    (in[g]),
      .level (level[g]),
      .rise  (rise[g]),
      .fall  (fall[g]),
      .hold  (hold[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debounce_bank
//  Purpose  : Scoreboard bench for debounce_bank (NUM_CH=2, LIMIT=4,
//             HOLD_LIMIT=8; TICK_DIV=1 main instance, TICK_DIV=4 second one).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_bank;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] in    = 2'b00;
  logic [1:0] level, rise, fall, hold;
  logic [1:0] in4   = 2'b00;
  logic [1:0] level4, rise4, fall4, hold4;

  always #5 clock = ~clock;

  debounce_bank #(
    .NUM_CH(2), .LIMIT(4), .TICK_DIV(1), .RESET_LEVEL(1'b0), .HOLD_LIMIT(8)
  ) dut (
    .clock(clock), .reset(reset), .in(in),
    .level(level), .rise(rise), .fall(fall), .hold(hold)
  );

  debounce_bank #(
    .NUM_CH(2), .LIMIT(4), .TICK_DIV(4), .RESET_LEVEL(1'b0), .HOLD_LIMIT(8)
  ) dut4 (
    .clock(clock), .reset(reset), .in(in4),
    .level(level4), .rise(rise4), .fall(fall4), .hold(hold4)
  );

  typedef struct {
    string      name;
    int         cyc;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] hold;
    logic [1:0] level;
  } ev_t;

  ev_t sb[$];
  ev_t e;
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every pulse cycle must match the oldest expected event.
  always @(negedge clock) begin
    if (!reset && ((rise | fall | hold) != 2'b00)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cyc=%0d rise=%b fall=%b hold=%b level=%b, required no pulse",
                 cyc, rise, fall, hold, level);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.rise !== rise || e.fall !== fall ||
            e.hold !== hold || e.level !== level) begin
          errors++;
          $display("FAIL %s: got cyc=%0d rise=%b fall=%b hold=%b level=%b, required cyc=%0d rise=%b fall=%b hold=%b level=%b",
                   e.name, cyc, rise, fall, hold, level, e.cyc, e.rise, e.fall, e.hold, e.level);
        end
      end
    end
  end

  task automatic expect_ev(input string name, input int dly, input logic [1:0] r,
                           input logic [1:0] f, input logic [1:0] h, input logic [1:0] l);
    ev_t x;
    x.name = name; x.cyc = cyc + dly; x.rise = r; x.fall = f; x.hold = h; x.level = l;
    sb.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_bad;
    int edge_at;
    int early;

    // Reset asserted mid-cycle; outputs must clear without a clock edge.
    #8 reset = 1'b1;
    #1;
    chk("reset_level", {30'd0, level}, 32'd0);
    chk("reset_pulses", {26'd0, rise, fall, hold}, 32'd0);
    chk("reset_level4", {30'd0, level4}, 32'd0);
    @(posedge clock); #3 reset = 1'b0;
    idle_bad = 0;
    repeat (20) begin
      @(negedge clock);
      if ((level | rise | fall | hold) != 2'b00) idle_bad++;
    end
    chk("idle_after_reset", idle_bad, 0);

    // Clean press and release on ch0.
    step(1);
    in[0] = 1'b1;
    expect_ev("press0", 6, 2'b01, 2'b00, 2'b00, 2'b01);
    step(5);
    chk("press0_not_early", {30'd0, level}, 32'd0);
    step(1);
    chk("press0_level", {30'd0, level}, 32'd1);
    in[0] = 1'b0;
    expect_ev("release0", 6, 2'b00, 2'b01, 2'b00, 2'b00);
    step(10);

    // Bounce: 3 high, 1 low, then steady high.
    in[0] = 1'b1;
    step(3);
    in[0] = 1'b0;
    step(1);
    in[0] = 1'b1;
    expect_ev("bounce_rise", 6, 2'b01, 2'b00, 2'b00, 2'b01);
    step(5);
    chk("bounce_no_early", {30'd0, level}, 32'd0);
    step(1);
    chk("bounce_level", {30'd0, level}, 32'd1);
    in[0] = 1'b0;
    expect_ev("bounce_fall", 6, 2'b00, 2'b01, 2'b00, 2'b00);
    step(10);

    // Independence: ch1 up, then ch0 rises and ch1 falls together.
    in[1] = 1'b1;
    expect_ev("ch1_press", 6, 2'b10, 2'b00, 2'b00, 2'b10);
    step(6);
    in = 2'b01;
    expect_ev("indep", 6, 2'b01, 2'b10, 2'b00, 2'b01);
    step(6);
    chk("indep_level", {30'd0, level}, 32'd1);
    in = 2'b00;
    expect_ev("ch0_release", 6, 2'b00, 2'b01, 2'b00, 2'b00);
    step(10);

    // Reset while ch0 count is 2; nothing must come out of it.
    in[0] = 1'b1;
    step(4);
    #3 reset = 1'b1;
    in[0] = 1'b0;
    #1;
    chk("reset_midcount_level", {30'd0, level}, 32'd0);
    @(posedge clock); #3 reset = 1'b0;
    idle_bad = 0;
    repeat (12) begin
      @(negedge clock);
      if (level != 2'b00) idle_bad++;
    end
    chk("after_midcount_reset", idle_bad, 0);

    // Long press: hold fires once (when built), never repeats.
    step(1);
    in[0] = 1'b1;
    expect_ev("long_press", 6, 2'b01, 2'b00, 2'b00, 2'b01);
`ifdef DEBOUNCE_HOLD_EN
    expect_ev("hold0", 14, 2'b00, 2'b00, 2'b01, 2'b01);
`endif
    step(40);
    chk("long_press_level", {30'd0, level}, 32'd1);
    in[0] = 1'b0;
    expect_ev("long_release", 6, 2'b00, 2'b01, 2'b00, 2'b00);
    step(10);

    // Prescaled instance: rise expected between edge 15 and 18.
    in4[0] = 1'b1;
    edge_at = 0;
    early = 0;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      if (level4[0] && edge_at == 0) begin
        edge_at = k;
        chk("prescale_rise_pulse", {30'd0, rise4}, 32'd1);
      end
      if (k < 15 && (level4 != 2'b00 || rise4 != 2'b00)) early++;
    end
    chk("prescale_nothing_early", early, 0);
    checks++;
    if (edge_at < 15 || edge_at > 18) begin
      errors++;
      $display("FAIL prescale_window: got edge %0d, required 15..18", edge_at);
    end
    in4[0] = 1'b0;
    step(4);

    chk("scoreboard_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
